ahb_wait_slave: RTL and testbench

- AHB-Lite responder (slave) with an 8-bit byte-wide SRAM, a programmable number of wait states and a two-cycle ERROR response.
- It is the responder counterpart to the system master, used to exercise hready stalls and error handling.
- Drops into the system top alongside the existing slaves, behind the decoder and the read multiplexor.

---
 rtl/ahb_wait_slave.sv | 146 ++++++++++++++
 tb/tb_ahb_wait_slave.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_wait_slave.sv
// rtl/ahb_wait_slave.sv - AHB-Lite byte SRAM responder with programmable wait states and ERROR response
//
// Ports:
//   hclk, hresetn        clock (rising edge) and asynchronous active-low reset
//   hsel, hready         decoder select and bus-level ready; address phase sampled when both high
//   haddr, hwrite        transfer address and direction (1 = write)
//   hsize, hburst        transfer size (only byte legal) and burst type (not decoded)
//   htrans               IDLE/BUSY/NONSEQ/SEQ; only NONSEQ/SEQ start an access
//   hwdata               write data, valid in the data phase
//   hreadyout, hresp     registered slave ready and response (0 = OKAY, 1 = ERROR)
//   hrdata               registered read data
module ahb_wait_slave #(
    parameter int ADDR_W      = 10,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [1:0]        htrans,
    input  logic              hready,
    input  logic [7:0]        hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [7:0]        hrdata
);

    localparam int         IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] addr_q;
    logic             write_q;

    logic [7:0]       mem [MEM_DEPTH];

    logic             accept;
    logic             acc_err;
    logic             commit;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_val;

    // Burst type and the SEQ/NONSEQ distinction carry no meaning for a single-byte SRAM.
    logic unused_bits;
    assign unused_bits = ^{hburst, htrans[0]};

    assign accept  = hsel & hready & htrans[1];
    assign acc_err = (hsize != 3'b000) | (32'(haddr) >= 32'(MEM_DEPTH));
    assign commit  = (state == S_DATA) && write_q;

    // Entering DATA from WAIT reads the latched address; with zero wait states
    // DATA is entered straight from the address phase, so the live haddr is used.
    // A write committing on the same edge to the same byte is forwarded.
    always_comb begin
        rd_idx = (state == S_WAIT) ? addr_q : haddr[IDX_W-1:0];
        rd_val = mem[rd_idx];
        if (commit && (addr_q == rd_idx)) begin
            rd_val = hwdata;
        end
    end

    // Memory has no reset; a transfer cut short by reset never reaches DATA, so it never writes.
    always_ff @(posedge hclk) begin
        if (commit) begin
            mem[addr_q] <= hwdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= 8'h00;
        end else begin
            case (state)
                // IDLE, DATA and ERR2 all end with hreadyout high, so each may take a new address phase.
                S_IDLE, S_DATA, S_ERR2: begin
                    if (accept) begin
                        addr_q  <= haddr[IDX_W-1:0];
                        write_q <= hwrite;
                        if (acc_err) begin
                            state     <= S_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state     <= S_WAIT;
                            wait_cnt  <= WS_INIT;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b0;
                        end else begin
                            state     <= S_DATA;
                            hreadyout <= 1'b1;
                            hresp     <= 1'b0;
                            if (!hwrite) begin
                                hrdata <= rd_val;
                            end
                        end
                    end else begin
                        state     <= S_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= S_DATA;
                        hreadyout <= 1'b1;
                        if (!write_q) begin
                            hrdata <= rd_val;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_wait_slave.sv
// tb/tb_ahb_wait_slave.sv - directed self-checking bench for ahb_wait_slave (2 wait states and 0 wait states)
module tb_ahb_wait_slave;

    logic       hclk;
    logic       hresetn;
    logic       hsel2;
    logic       hsel0;
    logic [9:0] haddr;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [1:0] htrans;
    logic       hready;
    logic [7:0] hwdata;
    logic       ro2, rsp2, ro0, rsp0;
    logic [7:0] rd2, rd0;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_wait_slave #(.ADDR_W(10), .MEM_DEPTH(256), .WAIT_STATES(2)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .htrans(htrans), .hready(hready), .hwdata(hwdata),
        .hreadyout(ro2), .hresp(rsp2), .hrdata(rd2)
    );

    ahb_wait_slave #(.ADDR_W(10), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .htrans(htrans), .hready(hready), .hwdata(hwdata),
        .hreadyout(ro0), .hresp(rsp0), .hrdata(rd0)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Single transfer on the 2-wait-state instance; returns observations only.
    task automatic xfer(input logic [9:0] a, input logic w, input logic [2:0] sz, input logic [7:0] wd,
                        output int stalls, output logic err_seen, output logic resp_end,
                        output logic [7:0] rdata);
        hsel2 = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = 2'd2; hready = 1'b1;
        @(negedge hclk);
        htrans = 2'd0; hsize = 3'd0; hwdata = wd; stalls = 0; err_seen = 1'b0;
        while (ro2 !== 1'b1 && stalls < 50) begin
            hready = 1'b0;
            if (rsp2 === 1'b1) err_seen = 1'b1;
            stalls++;
            @(negedge hclk);
        end
        hready = 1'b1;
        resp_end = rsp2;
        rdata = rd2;
    endtask

    task automatic test_reset();
        hresetn = 1'b0; hsel2 = 1'b0; hsel0 = 1'b0; haddr = '0; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; htrans = 2'd0; hready = 1'b1; hwdata = 8'h00;
        repeat (2) @(negedge hclk);
        n_tests++; if (ro2 !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout got=%b exp=1", ro2); end
        n_tests++; if (rsp2 !== 1'b0) begin n_fail++; $display("FAIL reset_hresp got=%b exp=0", rsp2); end
        n_tests++; if (rd2 !== 8'h00) begin n_fail++; $display("FAIL reset_hrdata got=%h exp=00", rd2); end
        n_tests++; if (rd0 !== 8'h00 || ro0 !== 1'b1) begin n_fail++; $display("FAIL reset_ws0 got rd=%h ro=%b exp rd=00 ro=1", rd0, ro0); end
        hresetn = 1'b1;
        @(negedge hclk);
    endtask

    task automatic test_wait_write_read();
        int st; logic es, re; logic [7:0] rd;
        xfer(10'h010, 1'b1, 3'd0, 8'hA5, st, es, re, rd);
        n_tests++; if (st != 2) begin n_fail++; $display("FAIL t1_wr_stalls got=%0d exp=2", st); end
        n_tests++; if (re !== 1'b0 || es) begin n_fail++; $display("FAIL t1_wr_resp got=%b exp=0", re); end
        xfer(10'h010, 1'b0, 3'd0, 8'h00, st, es, re, rd);
        n_tests++; if (st != 2) begin n_fail++; $display("FAIL t1_rd_stalls got=%0d exp=2", st); end
        n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL t1_rd_data got=%h exp=a5", rd); end
        @(negedge hclk);
    endtask

    task automatic test_zero_wait_bypass();
        hsel2 = 1'b0;
        hsel0 = 1'b1; haddr = 10'h020; hwrite = 1'b1; hsize = 3'd0; htrans = 2'd2; hready = 1'b1;
        @(negedge hclk);
        n_tests++; if (ro0 !== 1'b1) begin n_fail++; $display("FAIL t2_wr_nostall got=%b exp=1", ro0); end
        hwdata = 8'h3C; haddr = 10'h020; hwrite = 1'b0; htrans = 2'd2;
        @(negedge hclk);
        n_tests++; if (ro0 !== 1'b1 || rsp0 !== 1'b0) begin n_fail++; $display("FAIL t2_rd_okay got ro=%b resp=%b exp ro=1 resp=0", ro0, rsp0); end
        n_tests++; if (rd0 !== 8'h3C) begin n_fail++; $display("FAIL t2_bypass got=%h exp=3c", rd0); end
        htrans = 2'd0; hwdata = 8'h00;
        repeat (2) @(negedge hclk);
        haddr = 10'h020; hwrite = 1'b0; htrans = 2'd2;
        @(negedge hclk);
        n_tests++; if (rd0 !== 8'h3C) begin n_fail++; $display("FAIL t2_mem_rd got=%h exp=3c", rd0); end
        htrans = 2'd0; hsel0 = 1'b0;
        @(negedge hclk);
    endtask

    task automatic test_error();
        int st; logic es, re; logic [7:0] rd;
        xfer(10'h010, 1'b0, 3'd0, 8'h00, st, es, re, rd);
        n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL t3_pre_rd got=%h exp=a5", rd); end
        xfer(10'h1FF, 1'b0, 3'd0, 8'h00, st, es, re, rd);
        n_tests++; if (st != 1 || es !== 1'b1) begin n_fail++; $display("FAIL t3_oor_err1 got stalls=%0d err=%b exp 1/1", st, es); end
        n_tests++; if (re !== 1'b1) begin n_fail++; $display("FAIL t3_oor_err2 got=%b exp=1", re); end
        n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL t3_oor_hrdata got=%h exp=a5", rd); end
        @(negedge hclk);
        n_tests++; if (ro2 !== 1'b1 || rsp2 !== 1'b0) begin n_fail++; $display("FAIL t3_back_okay got ro=%b resp=%b exp 1/0", ro2, rsp2); end
        xfer(10'h005, 1'b1, 3'd0, 8'h77, st, es, re, rd);
        n_tests++; if (st != 2 || re !== 1'b0) begin n_fail++; $display("FAIL t3_wr_ok got stalls=%0d resp=%b exp 2/0", st, re); end
        xfer(10'h005, 1'b1, 3'd1, 8'hEE, st, es, re, rd);
        n_tests++; if (st != 1 || es !== 1'b1 || re !== 1'b1) begin n_fail++; $display("FAIL t3_size_err got stalls=%0d err=%b resp=%b exp 1/1/1", st, es, re); end
        xfer(10'h005, 1'b0, 3'd0, 8'h00, st, es, re, rd);
        n_tests++; if (rd !== 8'h77 || re !== 1'b0) begin n_fail++; $display("FAIL t3_unchanged got=%h resp=%b exp 77/0", rd, re); end
        @(negedge hclk);
    endtask

    task automatic test_burst_busy();
        logic [1:0] tr [6];
        logic [9:0] ad [6];
        logic [7:0] wd [5];
        logic [7:0] expd [4];
        int st [5];
        logic rs [5];
        int s; logic es, re; logic [7:0] rd;
        tr = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd0};
        ad = '{10'h040, 10'h041, 10'h042, 10'h042, 10'h043, 10'h043};
        wd = '{8'h11, 8'h22, 8'h00, 8'h33, 8'h44};
        expd = '{8'h11, 8'h22, 8'h33, 8'h44};
        hsel2 = 1'b1; hwrite = 1'b1; hsize = 3'd0; hburst = 3'd3; hready = 1'b1;
        htrans = tr[0]; haddr = ad[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge hclk);
            htrans = tr[i+1]; haddr = ad[i+1]; hwdata = wd[i]; st[i] = 0;
            while (ro2 !== 1'b1 && st[i] < 50) begin
                hready = 1'b0;
                st[i]++;
                @(negedge hclk);
            end
            hready = 1'b1;
            rs[i] = rsp2;
        end
        hburst = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (st[i] != ((i == 2) ? 0 : 2) || rs[i] !== 1'b0) begin
                n_fail++; $display("FAIL t4_phase%0d got stalls=%0d resp=%b exp stalls=%0d resp=0", i, st[i], rs[i], (i == 2) ? 0 : 2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            xfer(10'h040 + 10'(i), 1'b0, 3'd0, 8'h00, s, es, re, rd);
            n_tests++; if (rd !== expd[i]) begin n_fail++; $display("FAIL t4_readback%0d got=%h exp=%h", i, rd, expd[i]); end
        end
        @(negedge hclk);
    endtask

    task automatic test_hready_low_and_reset();
        int st; logic es, re; logic [7:0] rd;
        hsel2 = 1'b1; haddr = 10'h010; hwrite = 1'b1; hsize = 3'd0; htrans = 2'd2; hready = 1'b0; hwdata = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            n_tests++; if (ro2 !== 1'b1) begin n_fail++; $display("FAIL t5_hready_low%0d got=%b exp=1", i, ro2); end
        end
        hready = 1'b1; htrans = 2'd0;
        @(negedge hclk);
        haddr = 10'h010; hwrite = 1'b1; htrans = 2'd2; hready = 1'b1;
        @(negedge hclk);
        n_tests++; if (ro2 !== 1'b0) begin n_fail++; $display("FAIL t5_in_wait got=%b exp=0", ro2); end
        htrans = 2'd0; hwdata = 8'h99; hready = 1'b0;
        #2 hresetn = 1'b0;
        #1;
        n_tests++; if (ro2 !== 1'b1 || rsp2 !== 1'b0) begin n_fail++; $display("FAIL t5_async_rst got ro=%b resp=%b exp 1/0", ro2, rsp2); end
        n_tests++; if (rd2 !== 8'h00) begin n_fail++; $display("FAIL t5_rst_hrdata got=%h exp=00", rd2); end
        @(negedge hclk);
        hresetn = 1'b1; hready = 1'b1;
        @(negedge hclk);
        xfer(10'h010, 1'b0, 3'd0, 8'h00, st, es, re, rd);
        n_tests++; if (rd !== 8'hA5 || st != 2) begin n_fail++; $display("FAIL t5_mem_kept got=%h stalls=%0d exp a5/2", rd, st); end
        @(negedge hclk);
    endtask

    initial begin
        test_reset();
        test_wait_write_read();
        test_zero_wait_bypass();
        test_error();
        test_burst_busy();
        test_hready_low_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
